// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S audio recorder.
// Includes the peak-magnitude helper used when AUD_REC_PEAK_EN is defined.
package aud_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 20;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_L = 3'd1,
        SKIP   = 3'd2,
        SHIFT  = 3'd3,
        WRITE  = 3'd4,
        WAIT_H = 3'd5,
        PAUSE  = 3'd6
    } state_t;

    // Magnitude of a signed sample; -32768 saturates so the result fits 15 bits.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] smp);
        logic [SAMPLE_W-1:0] mag;
        if (smp == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (smp[SAMPLE_W-1]) begin
            mag = (~smp) + 16'd1;
        end else begin
            mag = smp;
        end
        return mag;
    endfunction

endpackage

// File: rtl/aud_recorder_i2s_shift_rx.sv
// Serial-to-parallel receiver for one 16-bit I2S word, MSB first, on the falling BCLK edge.
module i2s_shift_rx
    import aud_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                shift_en,
    input  logic                clr,
    input  logic                din,
    output logic                done,
    output logic [SAMPLE_W-1:0] sample
);

    logic [SAMPLE_W-2:0] sr_r;
    logic [3:0]          cnt_r;

    // Shift register and bit counter; the 16th bit goes straight to the output word.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_r  <= {(SAMPLE_W-1){1'b0}};
            cnt_r <= 4'd0;
        end else if (clr) begin
            sr_r  <= {(SAMPLE_W-1){1'b0}};
            cnt_r <= 4'd0;
        end else if (shift_en) begin
            sr_r  <= {sr_r[SAMPLE_W-3:0], din};
            cnt_r <= cnt_r + 4'd1;
        end
    end

    assign done   = shift_en && (cnt_r == 4'd15);
    assign sample = {sr_r, din};

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder writing 16-bit samples to SRAM, clocked on falling BCLK.
// Optional peak tracking is enabled with the AUD_REC_PEAK_EN macro.
module aud_recorder
    import aud_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_we,
    output logic [ADDR_W-1:0]   o_length,
    output logic                o_full,
    output logic [SAMPLE_W-1:0] o_peak
);

    state_t              state_r, state_nxt_s;
    logic                lrc_r;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [ADDR_W-1:0]   len_r, len_nxt_s;
    logic                full_r, full_nxt_s;
    logic [SAMPLE_W-1:0] data_r, data_nxt_s;
    logic                we_r;
    logic                frame_start_s, recording_s;
    logic                rx_done_s;
    logic [SAMPLE_W-1:0] rx_sample_s;

    assign frame_start_s = lrc_r && !i_lrc;
    assign recording_s   = (state_r == WAIT_L) || (state_r == SKIP) || (state_r == SHIFT) ||
                           (state_r == WRITE)  || (state_r == WAIT_H);

    i2s_shift_rx u_rx (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .shift_en (state_r == SHIFT),
        .clr      (state_r != SHIFT),
        .din      (i_data),
        .done     (rx_done_s),
        .sample   (rx_sample_s)
    );

    // Next-state and counter logic; a strobed write is always accounted for on WRITE exit.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        len_nxt_s   = len_r;
        full_nxt_s  = full_r;
        data_nxt_s  = data_r;

        if (state_r == WRITE) begin
            len_nxt_s = (len_r == ADDR_MAX) ? len_r : len_r + 20'd1;
            if (addr_r == ADDR_MAX) begin
                full_nxt_s = 1'b1;
            end else begin
                addr_nxt_s = addr_r + 20'd1;
            end
        end else begin
            len_nxt_s = len_r;
        end

        if ((i_stop && (state_r != IDLE)) || ((state_r == WRITE) && (addr_r == ADDR_MAX))) begin
            state_nxt_s = IDLE;
        end else if (i_pause && recording_s) begin
            state_nxt_s = PAUSE;
        end else if (i_start && ((state_r == IDLE) || (state_r == PAUSE))) begin
            state_nxt_s = WAIT_L;
            if (state_r == IDLE) begin
                addr_nxt_s = {ADDR_W{1'b0}};
                len_nxt_s  = {ADDR_W{1'b0}};
                full_nxt_s = 1'b0;
            end else begin
                addr_nxt_s = addr_r;
            end
        end else begin
            case (state_r)
                WAIT_L:  state_nxt_s = frame_start_s ? SKIP : WAIT_L;
                SKIP:    state_nxt_s = SHIFT;
                SHIFT: begin
                    if (rx_done_s) begin
                        state_nxt_s = WRITE;
                        data_nxt_s  = rx_sample_s;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
                WRITE:   state_nxt_s = WAIT_H;
                WAIT_H:  state_nxt_s = i_lrc ? WAIT_L : WAIT_H;
                default: state_nxt_s = state_r;
            endcase
        end
    end

    // State, LR-clock history and output registers.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            lrc_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            len_r   <= {ADDR_W{1'b0}};
            full_r  <= 1'b0;
            data_r  <= {SAMPLE_W{1'b0}};
            we_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lrc_r   <= i_lrc;
            addr_r  <= addr_nxt_s;
            len_r   <= len_nxt_s;
            full_r  <= full_nxt_s;
            data_r  <= data_nxt_s;
            we_r    <= (state_nxt_s == WRITE);
        end
    end

    assign o_address = addr_r;
    assign o_length  = len_r;
    assign o_full    = full_r;
    assign o_data    = data_r;
    assign o_we      = we_r;

`ifdef AUD_REC_PEAK_EN
    logic [SAMPLE_W-1:0] peak_r;
    logic [SAMPLE_W-1:0] mag_s;

    assign mag_s = abs_sat(data_r);

    // Peak magnitude since the last fresh take, folded in as the write completes.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak_r <= {SAMPLE_W{1'b0}};
        end else if (i_start && (state_r == IDLE)) begin
            peak_r <= {SAMPLE_W{1'b0}};
        end else if ((state_r == WRITE) && (mag_s > peak_r)) begin
            peak_r <= mag_s;
        end
    end

    assign o_peak = peak_r;
`else
    assign o_peak = {SAMPLE_W{1'b0}};
`endif

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder with a write scoreboard; honours AUD_REC_PEAK_EN.
module tb_aud_recorder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_lrc, i_data, i_start, i_pause, i_stop;
    logic [19:0] o_address, o_length;
    logic [15:0] o_data, o_peak;
    logic        o_we, o_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t         sb_q[$];
    logic [15:0] peak_m;

    aud_recorder dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_lrc     (i_lrc),
        .i_data    (i_data),
        .i_start   (i_start),
        .i_pause   (i_pause),
        .i_stop    (i_stop),
        .o_address (o_address),
        .o_data    (o_data),
        .o_we      (o_we),
        .o_length  (o_length),
        .o_full    (o_full),
        .o_peak    (o_peak)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] ref_abs(input logic [15:0] s);
        if (s == 16'h8000) return 16'h7FFF;
        if (s[15]) return 16'd0 - s;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_peak();
`ifdef AUD_REC_PEAK_EN
        chk("peak", 32'(o_peak), 32'(peak_m));
`else
        chk("peak_off", 32'(o_peak), 32'h0);
`endif
    endtask

    task automatic expect_write(input logic [19:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb_q.push_back(e);
        if (ref_abs(d) > peak_m) peak_m = ref_abs(d);
    endtask

    // ev = {stop, pause, start}; inputs change on the rising edge, DUT samples on the falling edge
    task automatic step(input logic lrc, input logic d, input logic [2:0] ev);
        i_lrc = lrc;
        i_data = d;
        {i_stop, i_pause, i_start} = ev;
        @(negedge i_clk);
        @(posedge i_clk);
        {i_stop, i_pause, i_start} = 3'b000;
    endtask

    task automatic idle_right(input int n, input logic [2:0] ev_first);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), (i == 0) ? ev_first : 3'b000);
    endtask

    task automatic send_frame(input logic [15:0] smp, input bit exp_we, input int ev_j,
                              input logic [2:0] ev, input bit rst_ev);
        logic d;
        for (int j = 0; j < 20; j++) begin
            d = (j >= 2 && j <= 17) ? smp[17-j] : 1'($urandom);
            if (rst_ev && j == ev_j) i_rst_n = 1'b0;
            step(1'b0, d, (j == ev_j) ? ev : 3'b000);
            i_rst_n = 1'b1;
            if (exp_we) chk("we_timing", 32'(o_we), (j == 17) ? 32'd1 : 32'd0);
        end
        idle_right(20, 3'b000);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected write
    always @(posedge i_clk) begin
        wr_t e;
        if (o_we === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_we observed addr=%h data=%h expected no write", o_address, o_data);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(o_address), 32'(e.a));
                chk("wr_data", 32'(o_data), 32'(e.d));
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_lrc = 1'b0; i_data = 1'b0;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        peak_m = 16'h0;
        repeat (3) @(posedge i_clk);
        i_rst_n = 1'b1;
        chk("rst_addr", 32'(o_address), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_we", 32'(o_we), 32'h0);
        chk("rst_len", 32'(o_length), 32'h0);
        chk("rst_full", 32'(o_full), 32'h0);
        chk_peak();

        // single frame with latency check
        idle_right(3, 3'b001);
        expect_write(20'h0, 16'hA5C3);
        send_frame(16'hA5C3, 1'b1, -1, 3'b000, 1'b0);
        chk("s1_addr", 32'(o_address), 32'h1);
        chk("s1_len", 32'(o_length), 32'h1);
        chk_peak();
        idle_right(2, 3'b100);
        chk("stop_len", 32'(o_length), 32'h1);
        chk("stop_data", 32'(o_data), 32'hA5C3);

        // three frames from a fresh take
        idle_right(2, 3'b001);
        peak_m = 16'h0;
        expect_write(20'h0, 16'h0001);
        send_frame(16'h0001, 1'b1, -1, 3'b000, 1'b0);
        expect_write(20'h1, 16'h8000);
        send_frame(16'h8000, 1'b1, -1, 3'b000, 1'b0);
        expect_write(20'h2, 16'h7FFF);
        send_frame(16'h7FFF, 1'b1, -1, 3'b000, 1'b0);
        chk("s3_len", 32'(o_length), 32'h3);
        chk("s3_addr", 32'(o_address), 32'h3);
        chk_peak();

        // pause mid-sample, then resume at held address
        send_frame(16'hFFFF, 1'b0, 10, 3'b010, 1'b0);
        chk("pause_addr", 32'(o_address), 32'h3);
        idle_right(2, 3'b001);
        expect_write(20'h3, 16'h1234);
        send_frame(16'h1234, 1'b1, -1, 3'b000, 1'b0);
        chk("resume_addr", 32'(o_address), 32'h4);
        chk("resume_len", 32'(o_length), 32'h4);

        // pause and stop together: stop wins, nothing more recorded
        send_frame(16'h0F0F, 1'b0, 8, 3'b110, 1'b0);
        chk("ps_len", 32'(o_length), 32'h4);
        send_frame(16'h4321, 1'b0, -1, 3'b000, 1'b0);
        chk("ps_idle_addr", 32'(o_address), 32'h4);

        // end of memory
        idle_right(1, 3'b001);
        peak_m = 16'h0;
        force dut.addr_r = 20'hFFFFE;
        idle_right(1, 3'b000);
        release dut.addr_r;
        idle_right(1, 3'b000);
        chk("forced_addr", 32'(o_address), 32'hFFFFE);
        expect_write(20'hFFFFE, 16'h1111);
        send_frame(16'h1111, 1'b1, -1, 3'b000, 1'b0);
        expect_write(20'hFFFFF, 16'h2222);
        send_frame(16'h2222, 1'b1, -1, 3'b000, 1'b0);
        chk("full_set", 32'(o_full), 32'h1);
        chk("full_addr", 32'(o_address), 32'hFFFFF);
        chk("full_len", 32'(o_length), 32'h2);
        send_frame(16'h3333, 1'b0, -1, 3'b000, 1'b0);
        chk("full_hold", 32'(o_full), 32'h1);
        idle_right(1, 3'b001);
        chk("full_clr", 32'(o_full), 32'h0);
        chk("full_restart_addr", 32'(o_address), 32'h0);
        idle_right(1, 3'b100);

        // reset in the middle of a sample
        idle_right(2, 3'b001);
        send_frame(16'h5A5A, 1'b0, 10, 3'b000, 1'b1);
        peak_m = 16'h0;
        chk("mrst_addr", 32'(o_address), 32'h0);
        chk("mrst_data", 32'(o_data), 32'h0);
        chk("mrst_we", 32'(o_we), 32'h0);
        chk("mrst_len", 32'(o_length), 32'h0);
        chk("mrst_full", 32'(o_full), 32'h0);
        chk_peak();
        idle_right(2, 3'b001);
        expect_write(20'h0, 16'h5555);
        send_frame(16'h5555, 1'b1, -1, 3'b000, 1'b0);
        chk("mrst_next_addr", 32'(o_address), 32'h1);
        chk_peak();

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
